// File: rtl/scope_hart_pkg.sv
// Shared constants and types for the multi-hart stall scope.
// SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN adds a 16-bit timestamp to each entry.
package scope_hart_pkg;

    localparam int NUM_EVT = 6;

    localparam int EVT_MEM_BUSY  = 0;
    localparam int EVT_DO_FENCE  = 1;
    localparam int EVT_REG_FENCE = 2;
    localparam int EVT_REG_PAUSE = 3;
    localparam int EVT_CEASE     = 4;
    localparam int EVT_RETIRE    = 5;

`ifdef SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif

    typedef enum logic [1:0] {
        SCOPE_IDLE    = 2'd0,
        SCOPE_ARMED   = 2'd1,
        SCOPE_CAPTURE = 2'd2,
        SCOPE_DONE    = 2'd3
    } scope_state_e;

endpackage

// File: rtl/scope_hart_stall_capture_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module scope_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scope_hart_stall_capture.sv
// Per-hart stall event counters plus a pre/post-trigger capture buffer.
// SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN prepends a cycle timestamp to entries.
module scope_hart_stall_capture
    import scope_hart_pkg::*;
#(
    parameter int NUM_HARTS = 2,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    localparam int DEPTH_W  = $clog2(DEPTH),
    localparam int EVT_W    = NUM_HARTS * NUM_EVT,
    localparam int ENT_W    = EVT_W + TS_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [EVT_W-1:0]   evt,
    input  logic               count_en,
    input  logic               clear,
    input  logic               arm,
    input  logic [HART_W-1:0]  trig_hart,
    input  logic [NUM_EVT-1:0] trig_mask,
    input  logic [DEPTH_W-1:0] post_trig,
    input  logic [HART_W-1:0]  cnt_rd_hart,
    input  logic [2:0]         cnt_rd_evt,
    output logic [CNT_W-1:0]   cnt_rd_data,
    input  logic [DEPTH_W-1:0] buf_rd_idx,
    output logic [ENT_W-1:0]   buf_rd_data,
    output logic [DEPTH_W:0]   buf_count,
    output logic [1:0]         state,
    output logic               done
);

    logic [CNT_W-1:0]   cnt [EVT_W];
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   wdata;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] post_cnt;
    logic [DEPTH_W-1:0] rd_addr;
    logic [NUM_EVT-1:0] hart_evt;
    logic               trig;
    logic               wr_en;
    logic               full;
    scope_state_e       state_q, state_d;

    for (genvar i = 0; i < EVT_W; i++) begin : g_cnt
        scope_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (count_en & evt[i]),
            .clear (clear),
            .count (cnt[i])
        );
    end

    always_comb begin
        cnt_rd_data = '0;
        for (int i = 0; i < EVT_W; i++) begin
            if ((int'(cnt_rd_hart) < NUM_HARTS) &&
                (int'(cnt_rd_evt) < NUM_EVT) &&
                (i == int'(cnt_rd_hart) * NUM_EVT + int'(cnt_rd_evt)))
                cnt_rd_data = cnt[i];
        end
    end

    // An out-of-range trig_hart matches no hart and so never triggers.
    always_comb begin
        hart_evt = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (h == int'(trig_hart))
                hart_evt = evt[h*NUM_EVT +: NUM_EVT];
        end
    end

    assign trig = |(hart_evt & trig_mask);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= SCOPE_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = SCOPE_IDLE;
        end else if (arm) begin
            state_d = SCOPE_ARMED;
        end else begin
            unique case (state_q)
                SCOPE_ARMED: begin
                    if (trig)
                        state_d = (post_trig == '0) ? SCOPE_DONE
                                                    : SCOPE_CAPTURE;
                end
                SCOPE_CAPTURE: begin
                    if (post_cnt == DEPTH_W'(1))
                        state_d = SCOPE_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        wr_en = !clear && !arm &&
                ((state_q == SCOPE_ARMED) || (state_q == SCOPE_CAPTURE));
        done  = (state_q == SCOPE_DONE);
        state = state_q;
    end

    assign full = (buf_count == (DEPTH_W+1)'(DEPTH));

    // post_trig is DEPTH_W bits wide, so it never exceeds DEPTH-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            buf_count <= '0;
            post_cnt  <= '0;
        end else if (clear || arm) begin
            wr_ptr    <= '0;
            buf_count <= '0;
            post_cnt  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + DEPTH_W'(1);
            if (!full)
                buf_count <= buf_count + (DEPTH_W+1)'(1);
            if (state_q == SCOPE_ARMED) begin
                if (trig) post_cnt <= post_trig;
            end else begin
                post_cnt <= post_cnt - DEPTH_W'(1);
            end
        end
    end

`ifdef SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

    assign wdata = {ts_q, evt};
`else
    assign wdata = evt;
`endif

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    // Once wrapped, the oldest sample sits at the write pointer.
    assign rd_addr = full ? (wr_ptr + buf_rd_idx) : buf_rd_idx;

    assign buf_rd_data = ({1'b0, buf_rd_idx} < buf_count) ? mem[rd_addr]
                                                          : '0;

endmodule

// File: tb/tb_scope_hart_stall_capture.sv
// Randomized and directed bench for scope_hart_stall_capture.
// A queue-based model of the capture window and counters supplies expectations.
module tb_scope_hart_stall_capture;
    import scope_hart_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic [11:0]        evt;
    logic               count_en;
    logic               clear;
    logic               arm;
    logic               trig_hart;
    logic [5:0]         trig_mask;
    logic [2:0]         post_trig;
    logic               cnt_rd_hart;
    logic [2:0]         cnt_rd_evt;
    logic [3:0]         cnt_rd_data;
    logic [2:0]         buf_rd_idx;
    logic [12+TS_W-1:0] buf_rd_data;
    logic [3:0]         buf_count;
    logic [1:0]         state;
    logic               done;

    int errors = 0;
    int checks = 0;

    int          m_state;
    int          m_post;
    logic [11:0] m_q[$];
    int          m_cnt[2][6];

    scope_hart_stall_capture #(
        .NUM_HARTS(2), .DEPTH(8), .CNT_W(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .evt         (evt),
        .count_en    (count_en),
        .clear       (clear),
        .arm         (arm),
        .trig_hart   (trig_hart),
        .trig_mask   (trig_mask),
        .post_trig   (post_trig),
        .cnt_rd_hart (cnt_rd_hart),
        .cnt_rd_evt  (cnt_rd_evt),
        .cnt_rd_data (cnt_rd_data),
        .buf_rd_idx  (buf_rd_idx),
        .buf_rd_data (buf_rd_data),
        .buf_count   (buf_count),
        .state       (state),
        .done        (done)
    );

    always #50 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_post  = 0;
        m_q.delete();
        for (int h = 0; h < 2; h++)
            for (int e = 0; e < 6; e++) m_cnt[h][e] = 0;
    endtask

    task automatic model_push();
        m_q.push_back(evt);
        if (m_q.size() > 8) void'(m_q.pop_front());
    endtask

    // Applied once per rising edge with the inputs present at that edge.
    task automatic model_edge();
        logic [5:0] he;
        logic       t;
        he = trig_hart ? evt[11:6] : evt[5:0];
        t  = |(he & trig_mask);
        for (int h = 0; h < 2; h++)
            for (int e = 0; e < 6; e++) begin
                if (clear) m_cnt[h][e] = 0;
                else if (count_en && evt[h*6+e] && m_cnt[h][e] < 15)
                    m_cnt[h][e]++;
            end
        if (clear) begin
            m_state = 0;
            m_q.delete();
        end else if (arm) begin
            m_state = 1;
            m_q.delete();
        end else if (m_state == 1) begin
            model_push();
            if (t) begin
                m_post  = int'(post_trig);
                m_state = (m_post == 0) ? 3 : 2;
            end
        end else if (m_state == 2) begin
            model_push();
            m_post--;
            if (m_post == 0) m_state = 3;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " state"}, 32'(state), 32'(m_state));
        check({tag, " done"}, 32'(done), 32'(m_state == 3));
        check({tag, " buf_count"}, 32'(buf_count), 32'(m_q.size()));
        for (int i = 0; i < 8; i++) begin
            buf_rd_idx = 3'(i);
            #1;
            check($sformatf("%s buf[%0d]", tag, i), 32'(buf_rd_data[11:0]),
                  (i < m_q.size()) ? 32'(m_q[i]) : 32'd0);
        end
        for (int h = 0; h < 2; h++)
            for (int e = 0; e < 8; e++) begin
                cnt_rd_hart = 1'(h);
                cnt_rd_evt  = 3'(e);
                #1;
                check($sformatf("%s cnt h%0d e%0d", tag, h, e),
                      32'(cnt_rd_data), (e < 6) ? 32'(m_cnt[h][e]) : 32'd0);
            end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic pulse_arm(input string tag);
        arm = 1'b1;
        step(tag);
        arm = 1'b0;
    endtask

    initial begin
        evt = '0; count_en = 1'b0; clear = 1'b0; arm = 1'b0;
        trig_hart = 1'b0; trig_mask = '0; post_trig = '0;
        cnt_rd_hart = 1'b0; cnt_rd_evt = '0; buf_rd_idx = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b1;
        step("idle");

        // Saturation of hart1 reg_pause, then clear.
        count_en = 1'b1;
        evt = 12'h200;
        for (int i = 0; i < 20; i++) step("sat");
        cnt_rd_hart = 1'b1; cnt_rd_evt = 3'd3; #1;
        check("sat direct", 32'(cnt_rd_data), 32'd15);
        clear = 1'b1;
        step("clear");
        clear = 1'b0;
        cnt_rd_hart = 1'b1; cnt_rd_evt = 3'd3; #1;
        check("clear direct", 32'(cnt_rd_data), 32'd0);
        evt = '0;

        // Post-trigger capture, trigger after ten pre-samples.
        trig_hart = 1'b0; trig_mask = 6'b000001; post_trig = 3'd3;
        pulse_arm("arm1");
        for (int c = 1; c <= 10; c++) begin
            evt = 12'(c * 2);
            step("pre");
        end
        evt = 12'h0A1;
        step("trig");
        for (int k = 0; k < 3; k++) begin
            evt = 12'h100 + 12'(2 * k);
            step("post");
        end
        evt = 12'h003;
        step("hold");
        check("post done", 32'(done), 32'd1);
        check("post count", 32'(buf_count), 32'd8);
        buf_rd_idx = 3'd4; #1;
        check("post trig idx", 32'(buf_rd_data[11:0]), 32'h0A1);
        buf_rd_idx = 3'd7; #1;
        check("post last idx", 32'(buf_rd_data[11:0]), 32'h104);

        // Early trigger before the buffer fills.
        post_trig = 3'd2;
        evt = '0;
        pulse_arm("arm2");
        evt = 12'h002; step("early");
        evt = 12'h004; step("early");
        evt = 12'h0A1; step("early trig");
        evt = 12'h006; step("early post");
        evt = 12'h008; step("early post");
        evt = 12'h00A; step("early hold");
        check("early count", 32'(buf_count), 32'd5);
        buf_rd_idx = 3'd2; #1;
        check("early trig idx", 32'(buf_rd_data[11:0]), 32'h0A1);

        // Priority and ignored triggers.
        arm = 1'b1; clear = 1'b1; evt = '0;
        step("arm+clear");
        clear = 1'b0;
        evt = 12'h001;
        step("arm+trig");
        arm = 1'b0;
        check("arm+trig state", 32'(state), 32'd1);
        trig_mask = '0;
        for (int i = 0; i < 12; i++) begin
            evt = 12'($urandom);
            step("mask0");
        end
        check("mask0 state", 32'(state), 32'd1);

        // post_trig = 0 and post_trig = 7.
        trig_mask = 6'b000001; post_trig = 3'd0; evt = '0;
        pulse_arm("arm3");
        evt = 12'h0F1; step("pt0 trig");
        evt = '0; step("pt0 hold");
        post_trig = 3'd7;
        pulse_arm("arm4");
        evt = 12'h0F1; step("pt7 trig");
        for (int i = 0; i < 7; i++) begin
            evt = 12'($urandom) & 12'hFFE;
            step("pt7 post");
        end
        check("pt7 done", 32'(done), 32'd1);

        // Reset asserted mid-capture.
        pulse_arm("arm5");
        evt = 12'h0F1; step("rst trig");
        evt = 12'h0F0; step("rst cap");
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst mid");
        reset = 1'b1;
        evt = 12'h001;
        step("rst after");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            evt       = 12'($urandom);
            count_en  = ($urandom_range(0, 3) != 0);
            arm       = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            trig_hart = 1'($urandom);
            trig_mask = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                        : (6'b1 << $urandom_range(0, 5));
            post_trig = 3'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
